// File: rtl/formula_enum_sequencer_if.sv
// ============================================================================
// Module   : formula_enum_sequencer_if
// Brief    : Harness/formula-facing signal bundle of formula_enum_sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface formula_enum_sequencer_if #(
   parameter int N_VARS = 19,
   parameter int CNT_W  = 20
);
   logic              start;
   logic              abort;
   logic [N_VARS-1:0] fix_mask;
   logic [N_VARS-1:0] fix_val;
   logic [N_VARS-1:0] asg;
   logic              f_out;
   logic              busy;
   logic              done;
   logic              cex_found;
   logic [N_VARS-1:0] cex;
   logic [CNT_W-1:0]  eval_count;

   modport master (
      output start, abort, fix_mask, fix_val, f_out,
      input  asg, busy, done, cex_found, cex, eval_count
   );

   modport slave (
      input  start, abort, fix_mask, fix_val, f_out,
      output asg, busy, done, cex_found, cex, eval_count
   );
endinterface

`default_nettype wire

// File: rtl/formula_enum_sequencer.sv
// ============================================================================
// Module   : formula_enum_sequencer
// Brief    : Walks a combinational formula through all free-variable
//            assignments, stopping at the first counterexample.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module formula_enum_sequencer #(
   parameter int N_VARS   = 19,
   parameter int EVAL_LAT = 1,
   parameter int CNT_W    = 20
) (
   input  logic                     clk,
   input  logic                     rst,
   formula_enum_sequencer_if.slave  bus
);

   localparam logic [3:0]        LAT     = 4'(EVAL_LAT);
   localparam logic [N_VARS-1:0] ONE_V   = N_VARS'(1);
   localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [3:0]        wait_cnt;
   logic [N_VARS-1:0] mask_l;
   logic [N_VARS-1:0] val_l;
   logic [N_VARS-1:0] asg;
   logic [N_VARS-1:0] cex;
   logic              cex_found;
   logic [CNT_W-1:0]  eval_count;

   logic              accept;
   logic              take;
   logic              free_wrapped;
   logic [N_VARS-1:0] asg_step;

   // Pinned bits are forced to 1 so the carry ripples straight across them.
   assign free_wrapped = &(asg | mask_l);
   assign asg_step     = (((asg | mask_l) + ONE_V) & ~mask_l) | (val_l & mask_l);

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      take      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = EVAL;
            end
         end
         EVAL: begin
            if (bus.abort) begin
               state_nxt = IDLE;
            end else if (wait_cnt == LAT) begin
               take = 1'b1;
               if (!bus.f_out || free_wrapped) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt   <= '0;
         mask_l     <= '0;
         val_l      <= '0;
         asg        <= '0;
         cex        <= '0;
         cex_found  <= 1'b0;
         eval_count <= '0;
      end else if (accept) begin
         mask_l     <= bus.fix_mask;
         val_l      <= bus.fix_val;
         asg        <= bus.fix_val & bus.fix_mask;
         cex        <= '0;
         cex_found  <= 1'b0;
         eval_count <= '0;
         wait_cnt   <= '0;
      end else if (take) begin
         if (eval_count != '1) begin
            eval_count <= eval_count + ONE_C;
         end
         if (!bus.f_out) begin
            cex       <= asg;
            cex_found <= 1'b1;
         end else if (!free_wrapped) begin
            asg      <= asg_step;
            wait_cnt <= '0;
         end
      end else if (state == EVAL && !bus.abort) begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

   assign bus.asg        = asg;
   assign bus.busy       = (state == EVAL);
   assign bus.done       = (state == DONE);
   assign bus.cex_found  = cex_found;
   assign bus.cex        = cex;
   assign bus.eval_count = eval_count;

endmodule

`default_nettype wire

// File: tb/tb_formula_enum_sequencer.sv
// ============================================================================
// Module   : tb_formula_enum_sequencer
// Brief    : Directed scoreboard bench for formula_enum_sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_formula_enum_sequencer;

   localparam int N_VARS   = 19;
   localparam int EVAL_LAT = 1;
   localparam int CNT_W    = 20;
   localparam int P        = EVAL_LAT + 1;
   localparam int LIMIT    = 200;

   typedef struct {
      logic              cf;
      logic [N_VARS-1:0] cex;
      logic [CNT_W-1:0]  cnt;
      logic [N_VARS-1:0] last;
   } res_t;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   fmode  = 0;

   logic [N_VARS-1:0] asg_q[$];
   res_t              res_q[$];

   formula_enum_sequencer_if #(.N_VARS(N_VARS), .CNT_W(CNT_W)) bus ();

   formula_enum_sequencer #(
      .N_VARS  (N_VARS),
      .EVAL_LAT(EVAL_LAT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic formula(input int mode, input logic [N_VARS-1:0] a);
      case (mode)
         1:       return (a != 19'h5);
         2:       return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   always_comb bus.f_out = formula(fmode, bus.asg);

   // Deposit the bits of idx into the free positions, lowest first.
   function automatic logic [N_VARS-1:0] spread(input logic [N_VARS-1:0] mask,
                                                input logic [N_VARS-1:0] val,
                                                input int idx);
      logic [N_VARS-1:0] a;
      int b;
      a = val & mask;
      b = 0;
      for (int i = 0; i < N_VARS; i++) begin
         if (!mask[i]) begin
            a[i] = idx[b];
            b++;
         end
      end
      return a;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run(input logic [N_VARS-1:0] mask, input logic [N_VARS-1:0] val,
                      input int mode, input bit poke_start, input bit with_abort);
      res_t r;
      res_t got;
      logic [N_VARS-1:0] a;
      int nfree;
      int cyc;
      nfree = 0;
      for (int i = 0; i < N_VARS; i++) if (!mask[i]) nfree++;
      r.cf = 1'b0; r.cex = '0; r.cnt = '0; r.last = '0;
      for (int idx = 0; idx < (1 << nfree); idx++) begin
         a = spread(mask, val, idx);
         asg_q.push_back(a);
         r.cnt++;
         r.last = a;
         if (!formula(mode, a)) begin
            r.cf  = 1'b1;
            r.cex = a;
            break;
         end
      end
      res_q.push_back(r);

      fmode        = mode;
      bus.fix_mask = mask;
      bus.fix_val  = val;
      bus.start    = 1'b1;
      bus.abort    = with_abort;
      tick();
      bus.start    = 1'b0;
      bus.abort    = 1'b0;
      bus.fix_mask = ~mask;
      bus.fix_val  = ~val;
      chk("busy_after_start", 32'(bus.busy), 32'd1);

      cyc = 0;
      while (!bus.done && cyc < LIMIT) begin
         if (cyc % P == 0 && asg_q.size() > 0) begin
            a = asg_q.pop_front();
            chk("asg", 32'(bus.asg), 32'(a));
         end
         if (poke_start && cyc == 3) bus.start = 1'b1;
         tick();
         bus.start = 1'b0;
         cyc++;
      end
      chk("done_latency", 32'(cyc), 32'(P) * 32'(r.cnt));
      chk("asg_left", 32'(asg_q.size()), 32'd0);
      asg_q.delete();

      got = res_q.pop_front();
      chk("cex_found", 32'(bus.cex_found), 32'(got.cf));
      chk("cex", 32'(bus.cex), 32'(got.cex));
      chk("eval_count", 32'(bus.eval_count), 32'(got.cnt));
      chk("busy_in_done", 32'(bus.busy), 32'd0);
      tick();
      chk("done_one_cycle", 32'(bus.done), 32'd0);
      chk("asg_held", 32'(bus.asg), 32'(got.last));
      chk("cex_found_held", 32'(bus.cex_found), 32'(got.cf));
   endtask

   initial begin
      bit seen_done;
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.abort    = 1'b0;
      bus.fix_mask = '0;
      bus.fix_val  = '0;
      tick();
      tick();
      chk("rst_asg", 32'(bus.asg), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_cex_found", 32'(bus.cex_found), 32'd0);
      chk("rst_eval_count", 32'(bus.eval_count), 32'd0);
      rst = 1'b0;
      bus.abort = 1'b1;
      tick();
      chk("abort_idle_ignored", 32'(bus.busy), 32'd0);
      bus.abort = 1'b0;

      run(19'h7FFF8, 19'h0, 0, 1'b0, 1'b0);
      run(19'h7FFF8, 19'h0, 1, 1'b0, 1'b0);
      run(19'h7FFFF, 19'h2A5C3, 2, 1'b0, 1'b0);
      run(19'h7FFF5, 19'h4, 0, 1'b1, 1'b0);
      chk("pinned_last_asg", 32'(bus.asg), 32'hE);

      // Abort landing on the third sampling edge discards that sample.
      fmode        = 0;
      bus.fix_mask = 19'h7FFF8;
      bus.fix_val  = '0;
      bus.start    = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (5) tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_eval_count", 32'(bus.eval_count), 32'd2);
      chk("abort_asg", 32'(bus.asg), 32'd2);
      chk("abort_cex_found", 32'(bus.cex_found), 32'd0);
      seen_done = bus.done;
      for (int i = 0; i < 6; i++) begin
         tick();
         seen_done = seen_done | bus.done;
      end
      chk("abort_no_done", 32'(seen_done), 32'd0);
      chk("abort_count_held", 32'(bus.eval_count), 32'd2);

      // Asynchronous reset in the middle of a run.
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (5) tick();
      #2 rst = 1'b1;
      #1;
      chk("midrst_asg", 32'(bus.asg), 32'd0);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_eval_count", 32'(bus.eval_count), 32'd0);
      chk("midrst_done", 32'(bus.done), 32'd0);
      #1 rst = 1'b0;
      tick();
      tick();
      run(19'h7FFF8, 19'h0, 1, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
